// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: the byte-push handshake from the debug unit, plus the
// FIFO status flags, the serializer status and the TX pin that the
// transmitter returns.
// master: the debug unit side (pushes bytes, watches the flags).
// slave:  the uart_tx_fifo side.
interface uart_tx_fifo_if;
    logic       wr_uart;
    logic [7:0] data_uart;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx;

    modport master (
        output wr_uart,
        output data_uart,
        input  tx_full,
        input  tx_empty,
        input  tx_busy,
        input  tx
    );

    modport slave (
        input  wr_uart,
        input  data_uart,
        output tx_full,
        output tx_empty,
        output tx_busy,
        output tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte-wide transmit FIFO feeding a UART serializer.
// The baud timing comes from an internal 16x oversampling tick generator.
// The FIFO flags, the busy flag and the TX line are all registered.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even
// parity bit is sent between the last data bit and the stop bit (8E1).
// When it is undefined, the frame is plain 8N1.
module uart_tx_fifo #(
    parameter int DBIT          = 8,
    parameter int SB_TICK       = 16,
    parameter int CLKS_PER_TICK = 326,
    parameter int FIFO_AW       = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    uart_tx_fifo_if.slave bus
);

    localparam int              TW      = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int              SMAX    = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int              SW      = $clog2(SMAX);
    localparam int              BW      = $clog2(DBIT);
    localparam int              DEPTH   = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    // FIFO storage and bookkeeping
    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wptr_r;
    logic [FIFO_AW-1:0] rptr_r;
    logic [FIFO_AW:0]   count_r;
    logic [FIFO_AW:0]   count_next_s;
    logic               full_r;
    logic               empty_r;
    logic               push_s;
    logic               pop_s;

    // Tick generator
    logic [TW-1:0]      tick_cnt_r;
    logic               tick_s;

    // Serializer state and datapath
    state_t             state_r;
    state_t             state_next_s;
    logic [SW-1:0]      s_r;
    logic [SW-1:0]      s_next_s;
    logic [BW-1:0]      b_r;
    logic [BW-1:0]      b_next_s;
    logic [DBIT-1:0]    shift_r;
    logic [DBIT-1:0]    shift_next_s;
`ifdef UART_TX_PARITY_EN
    logic               parity_r;
    logic               parity_next_s;
`endif
    logic               tx_r;
    logic               tx_next_s;
    logic               busy_r;
    logic               busy_next_s;

    // A push while full is dropped. Fullness is judged on the registered
    // flag, so a pop in the same cycle does not rescue the push.
    assign push_s = bus.wr_uart && !full_r;
    assign tick_s = (tick_cnt_r == TW'(CLKS_PER_TICK - 1));

    assign bus.tx_full  = full_r;
    assign bus.tx_empty = empty_r;
    assign bus.tx_busy  = busy_r;
    assign bus.tx       = tx_r;

    // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel out
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (FIFO_AW+1)'(1);
            2'b01:   count_next_s = count_r - (FIFO_AW+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO pointers, count and registered full/empty flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            empty_r <= 1'b1;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + FIFO_AW'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + FIFO_AW'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == DEPTH_C);
            empty_r <= (count_next_s == '0);
        end
    end

    // FIFO storage write port; the contents are meaningful only between the pointers
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_r[wptr_r] <= bus.data_uart;
        end
    end

    // Oversampling tick counter, restarted when a frame begins so that each frame is phase-aligned
    always_ff @(posedge CLK) begin
        if (RESET || pop_s || tick_s) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + TW'(1);
        end
    end

    // Serializer state register and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r  <= ST_IDLE;
            s_r      <= '0;
            b_r      <= '0;
            shift_r  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_next_s;
            s_r      <= s_next_s;
            b_r      <= b_next_s;
            shift_r  <= shift_next_s;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_next_s;
`endif
        end
    end

    // Serializer next-state and datapath update, stepped by oversampling ticks
    always_comb begin
        state_next_s  = state_r;
        s_next_s      = s_r;
        b_next_s      = b_r;
        shift_next_s  = shift_r;
`ifdef UART_TX_PARITY_EN
        parity_next_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_next_s  = ST_START;
                    s_next_s      = '0;
                    b_next_s      = '0;
                    shift_next_s  = mem_r[rptr_r][DBIT-1:0];
`ifdef UART_TX_PARITY_EN
                    parity_next_s = ^mem_r[rptr_r][DBIT-1:0];
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (s_r == SW'(15)) begin
                        s_next_s     = '0;
                        state_next_s = ST_DATA;
                    end else begin
                        s_next_s = s_r + SW'(1);
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (s_r == SW'(15)) begin
                        s_next_s     = '0;
                        shift_next_s = {1'b0, shift_r[DBIT-1:1]};
                        if (b_r == BW'(DBIT - 1)) begin
                            b_next_s = '0;
`ifdef UART_TX_PARITY_EN
                            state_next_s = ST_PARITY;
`else
                            state_next_s = ST_STOP;
`endif
                        end else begin
                            b_next_s     = b_r + BW'(1);
                            state_next_s = ST_DATA;
                        end
                    end else begin
                        s_next_s = s_r + SW'(1);
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    if (s_r == SW'(15)) begin
                        s_next_s     = '0;
                        state_next_s = ST_STOP;
                    end else begin
                        s_next_s = s_r + SW'(1);
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    if (s_r == SW'(SB_TICK - 1)) begin
                        s_next_s     = '0;
                        state_next_s = ST_IDLE;
                    end else begin
                        s_next_s = s_r + SW'(1);
                    end
                end else begin
                    s_next_s = s_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                s_next_s     = '0;
                b_next_s     = '0;
            end
        endcase
    end

    // Serializer outputs: the pop request, and the line/busy values for the upcoming state
    always_comb begin
        pop_s       = (state_r == ST_IDLE) && !empty_r;
        busy_next_s = (state_next_s != ST_IDLE);
        case (state_next_s)
            ST_IDLE:   tx_next_s = 1'b1;
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_next_s = parity_next_s;
`endif
            ST_STOP:   tx_next_s = 1'b1;
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Registered line and busy outputs, so that they change together with the state
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
        end else begin
            tx_r   <= tx_next_s;
            busy_r <= busy_next_s;
        end
    end

endmodule
